// File: rtl/tv_sequencer.sv
// tv_sequencer: RAM-backed test-vector player that drives a small DUT,
// samples its response after a settle time and counts mismatches.
module tv_sequencer #(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 256,
    parameter int SETTLE = 1,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int VEC_W  = 1 + IN_W + OUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [VEC_W-1:0]  load_data,
    input  logic              start,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       errors,
    output logic [ADDR_W:0]   vectornum,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_vector
);
    typedef enum logic [2:0] {IDLE, FETCH, APPLY, WAIT, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [VEC_W-1:0] mem [DEPTH];
    logic [VEC_W-1:0] rd;
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0] exp_r;
    logic [31:0] cnt;
    logic go, last, mismatch;

    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
    assign pass = done && errors == '0;
    assign go = start && !busy;
    assign last = &addr;
    // case inequality so an X/Z response is scored as a mismatch in simulation
    assign mismatch = dut_out !== exp_r;

    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
        rd <= mem[addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = go ? FETCH : state;
            FETCH:      state_n = APPLY;
            APPLY:      state_n = rd[VEC_W-1] ? WAIT : DONE;
            WAIT:       state_n = cnt == 32'd1 ? CHECK : WAIT;
            CHECK:      state_n = last ? DONE : FETCH;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dut_in     <= '0;
            exp_r      <= '0;
            cnt        <= '0;
            addr       <= '0;
            errors     <= '0;
            vectornum  <= '0;
            err_pulse  <= 1'b0;
            err_vector <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (go) begin
                addr       <= '0;
                errors     <= '0;
                vectornum  <= '0;
                err_vector <= '0;
            end
            if (state == APPLY && rd[VEC_W-1]) begin
                dut_in <= rd[VEC_W-2 -: IN_W];
                exp_r  <= rd[OUT_W-1:0];
                cnt    <= 32'(SETTLE);
            end
            if (state == WAIT)
                cnt <= cnt - 1'b1;
            if (state == CHECK) begin
                vectornum <= vectornum + 1'b1;
                if (!last)
                    addr <= addr + 1'b1;
                if (mismatch) begin
                    err_pulse  <= 1'b1;
                    err_vector <= addr;
                    if (errors != '1)
                        errors <= errors + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tv_sequencer.sv
// tb_tv_sequencer: two sequencers (1-bit/SETTLE=1 wire DUT, 2-bit/SETTLE=3 delay-line DUT)
// checked against a vector-list model of run length, error count and timing.
module tb_tv_sequencer;
    logic clk = 1'b0;
    logic reset, start, load_en;
    logic [2:0] load_addr;
    logic [2:0] load_data0;
    logic [4:0] load_data1;
    logic [0:0] din0, dout0;
    logic [1:0] din1, dout1;
    logic [1:0] d1 = '0, d2 = '0, d3 = '0;
    logic busy_v [2], done_v [2], pass_v [2], ep_v [2];
    logic [31:0] err_v [2];
    logic [3:0] vn_v [2];
    logic [2:0] ev_v [2];
    int v [2][8], s [2][8], e [2][8];
    int settle [2] = '{1, 3};
    int ncmp = 0, nbad = 0;

    always #5 clk = ~clk;

    assign dout0 = din0;
    always @(posedge clk) begin
        d1 <= din1;
        d2 <= d1;
        d3 <= d2;
    end
    assign dout1 = d3;

    tv_sequencer #(.IN_W(1), .OUT_W(1), .DEPTH(8), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data0), .start(start), .dut_in(din0), .dut_out(dout0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .errors(err_v[0]),
        .vectornum(vn_v[0]), .err_pulse(ep_v[0]), .err_vector(ev_v[0]));

    tv_sequencer #(.IN_W(2), .OUT_W(2), .DEPTH(8), .SETTLE(3)) u1 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data1), .start(start), .dut_in(din1), .dut_out(dout1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .errors(err_v[1]),
        .vectornum(vn_v[1]), .err_pulse(ep_v[1]), .err_vector(ev_v[1]));

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_busy%0d", tag, k), busy_v[k], 0);
            check($sformatf("%s_done%0d", tag, k), done_v[k], 0);
            check($sformatf("%s_pass%0d", tag, k), pass_v[k], 0);
            check($sformatf("%s_errors%0d", tag, k), err_v[k], 0);
            check($sformatf("%s_vnum%0d", tag, k), vn_v[k], 0);
            check($sformatf("%s_epulse%0d", tag, k), ep_v[k], 0);
            check($sformatf("%s_evec%0d", tag, k), ev_v[k], 0);
        end
        check($sformatf("%s_din0", tag), din0, 0);
        check($sformatf("%s_din1", tag), din1, 0);
    endtask

    // Run length is the index of the first invalid vector; every checked vector
    // whose stimulus differs from its expected value is one error.
    function automatic void model(input int k, output int n, output int errs,
                                  output int lst, output int cyc);
        n = 8;
        errs = 0;
        lst = 0;
        for (int i = 7; i >= 0; i--)
            if (v[k][i] == 0) n = i;
        for (int i = 0; i < n; i++)
            if (s[k][i] != e[k][i]) begin
                errs++;
                lst = i;
            end
        cyc = n * (settle[k] + 3) + (n < 8 ? 2 : 0);
    endfunction

    task automatic write_all();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_en = 1'b1;
            load_addr = 3'(i);
            load_data0 = 3'(v[0][i] * 4 + s[0][i] * 2 + e[0][i]);
            load_data1 = 5'(v[1][i] * 16 + s[1][i] * 4 + e[1][i]);
        end
        @(negedge clk) load_en = 1'b0;
    endtask

    task automatic run(input string tag, input bit disturb);
        int t [2] = '{-1, -1};
        int np [2] = '{0, 0};
        int bz [2] = '{0, 0};
        int n, errs, lst, cyc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_clr_err%0d", tag, k), err_v[k], 0);
            check($sformatf("%s_clr_done%0d", tag, k), done_v[k], 0);
        end
        for (int c = 1; c <= 120 && (t[0] < 0 || t[1] < 0); c++) begin
            if (disturb && c == 5) begin
                start = 1'b1;
                load_en = 1'b1;
                load_addr = 3'd1;
                load_data0 = 3'(4 + (1 - s[0][1]) * 2 + s[0][1]);
                load_data1 = 5'(16 + (3 - s[1][1]) * 4 + s[1][1]);
            end
            @(negedge clk);
            start = 1'b0;
            load_en = 1'b0;
            for (int k = 0; k < 2; k++)
                if (t[k] < 0) begin
                    if (ep_v[k]) np[k]++;
                    if (done_v[k]) t[k] = c;
                    else if (!busy_v[k]) bz[k]++;
                end
        end
        for (int k = 0; k < 2; k++) begin
            model(k, n, errs, lst, cyc);
            check($sformatf("%s_cycles%0d", tag, k), t[k], cyc);
            check($sformatf("%s_vnum%0d", tag, k), vn_v[k], n);
            check($sformatf("%s_errors%0d", tag, k), err_v[k], errs);
            check($sformatf("%s_pulses%0d", tag, k), np[k], errs);
            check($sformatf("%s_evec%0d", tag, k), ev_v[k], lst);
            check($sformatf("%s_pass%0d", tag, k), pass_v[k], errs == 0);
            check($sformatf("%s_idle_gap%0d", tag, k), bz[k], 0);
            check($sformatf("%s_busy_end%0d", tag, k), busy_v[k], 0);
        end
    endtask

    task automatic set_t1();
        int st [4] = '{0, 1, 1, 0};
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                v[k][i] = i == 4 ? 0 : 1;
                s[k][i] = i < 4 ? st[i] * (k ? 3 : 1) : int'($urandom_range(0, k ? 3 : 1));
                e[k][i] = s[k][i];
            end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data0 = '0;
        load_data1 = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        // leading sentinel
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                v[k][i] = i == 0 ? 0 : 1;
                s[k][i] = $urandom_range(0, k ? 3 : 1);
                e[k][i] = $urandom_range(0, k ? 3 : 1);
            end
        write_all();
        run("sentinel0", 0);
        check("sentinel0_din0", din0, 0);
        check("sentinel0_din1", din1, 0);
        set_t1();
        write_all();
        run("clean4", 0);
        e[0][2] = 0;
        e[1][2] = 2;
        write_all();
        run("mism2", 0);
        run("disturb", 1);
        e[0][2] = s[0][2];
        e[1][2] = s[1][2];
        write_all();
        run("rerun", 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                v[k][i] = 1;
                s[k][i] = $urandom_range(0, k ? 3 : 1);
                e[k][i] = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, k ? 3 : 1)) : s[k][i];
            end
        write_all();
        run("full8", 0);
        set_t1();
        write_all();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1 check_idle("abort");
        @(negedge clk) reset = 1'b0;
        run("after_abort", 0);
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 2; k++) begin
                int n = $urandom_range(0, 8);
                for (int i = 0; i < 8; i++) begin
                    v[k][i] = i < n ? 1 : (i == n ? 0 : int'($urandom_range(0, 1)));
                    s[k][i] = $urandom_range(0, k ? 3 : 1);
                    e[k][i] = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, k ? 3 : 1)) : s[k][i];
                end
            end
            write_all();
            run($sformatf("rand%0d", r), r[0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
